// File: rtl/aes_key_expand_if.sv
// Key-load handshake and round-key read port of the AES-128 key schedule.
// master = key source / round datapath, slave = aes_key_expand.
interface aes_key_expand_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    modport master (
        output key_in, key_valid, rk_addr,
        input  key_ready, busy, keys_valid, rk_data
    );

    modport slave (
        input  key_in, key_valid, rk_addr,
        output key_ready, busy, keys_valid, rk_data
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts a cipher key, derives round keys
// 1..10 one per clock into an 11-entry register file, and serves any round
// key through a registered read port.
module aes_key_expand (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_expand_if.slave   bus
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // Forward AES S-box, row-major, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        int idx;
        idx = 255 - int'(a);
        return SBOX_TABLE[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    state_t       state;
    logic [3:0]   round_cnt;
    logic [7:0]   rcon;
    logic [127:0] wk;
    logic [127:0] rk [0:10];

    logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0]  rot, t;
    logic [127:0] nk;
    logic [127:0] rd_sel;

    // One expansion step from the working key: SubWord/RotWord/rcon, then the XOR chain.
    always_comb begin
        w0  = wk[127:96];
        w1  = wk[95:64];
        w2  = wk[63:32];
        w3  = wk[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon, 24'h0};
        w4  = w0 ^ t;
        w5  = w1 ^ w4;
        w6  = w2 ^ w5;
        w7  = w3 ^ w6;
        nk  = {w4, w5, w6, w7};
    end

    // Read mux; addresses above 10 select zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < 11; i++) begin
            if (bus.rk_addr == 4'(i)) rd_sel = rk[i];
        end
    end

    // Control FSM plus schedule state; all handshake outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.key_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.keys_valid <= 1'b0;
            round_cnt      <= '0;
            rcon           <= '0;
            wk             <= '0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.key_valid && bus.key_ready) begin
                        rk[0]          <= bus.key_in;
                        wk             <= bus.key_in;
                        round_cnt      <= 4'd1;
                        rcon           <= 8'h01;
                        bus.keys_valid <= 1'b0;
                        bus.key_ready  <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= EXPAND;
                    end
                end
                EXPAND: begin
                    // key_valid is deliberately ignored here; no queuing.
                    for (int i = 1; i < 11; i++) begin
                        if (round_cnt == 4'(i)) rk[i] <= nk;
                    end
                    wk        <= nk;
                    rcon      <= xtime(rcon);
                    round_cnt <= round_cnt + 4'd1;
                    if (round_cnt == 4'd10) begin
                        bus.keys_valid <= 1'b1;
                        bus.key_ready  <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port; a same-edge write is not forwarded (pre-write value).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rk_data <= '0;
        else        bus.rk_data <= rd_sel;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: random and known-answer keys checked against a
// word-level FIPS-197 key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine transform.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    aes_key_expand_if bus();

    aes_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] ref_rk [11];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offers a key at a falling edge; returns at the falling edge after E0.
    task automatic accept(input string tag, input logic [127:0] k);
        chk({tag, "_ready_before"}, 128'(bus.key_ready), 128'(1));
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk({tag, "_busy_after_e0"}, 128'(bus.busy), 128'(1));
        chk({tag, "_ready_after_e0"}, 128'(bus.key_ready), 128'(0));
        chk({tag, "_kv_after_e0"}, 128'(bus.keys_valid), 128'(0));
    endtask

    // Waits (bounded) for keys_valid; 'start' is the edge count already elapsed.
    task automatic wait_done(input string tag, input int start);
        int c;
        c = start;
        while (!bus.keys_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 128'(c), 128'(10));
        chk({tag, "_ready_done"}, 128'(bus.key_ready), 128'(1));
        chk({tag, "_busy_done"}, 128'(bus.busy), 128'(0));
    endtask

    task automatic read_one(input string tag, input int a, input logic [127:0] exp);
        bus.rk_addr = 4'(a);
        @(negedge clk);
        chk(tag, bus.rk_data, exp);
    endtask

    task automatic read_sweep(input string tag, input bit zeros);
        for (int a = 0; a < 16; a++)
            read_one($sformatf("%s_rd%0d", tag, a), a, (a <= 10 && !zeros) ? ref_rk[a] : 128'h0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, 128'(bus.key_ready), 128'(1));
        chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
        chk({tag, "_kv"}, 128'(bus.keys_valid), 128'(0));
        chk({tag, "_rdata"}, bus.rk_data, 128'h0);
    endtask

    logic [127:0] key_a, key_b, a_rk3, a_rk10, b_rk3, kk;

    initial begin
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_addr   = '0;
        build_sbox();

        // Reset, asserted between clock edges.
        #2 rst_n = 1'b0;
        #1 reset_checks("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        read_sweep("rst0", 1'b1);

        // FIPS-197 known answer.
        kk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand_ref(kk);
        accept("fips", kk);
        wait_done("fips", 0);
        read_one("fips_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_one("fips_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_sweep("fips", 1'b0);

        // Codebase key.
        kk = 128'h5468617473206d79204b756e67204675;
        expand_ref(kk);
        accept("cb", kk);
        wait_done("cb", 0);
        read_one("cb_rk0", 0, 128'h5468617473206d79204b756e67204675);
        read_one("cb_rk1", 1, 128'he232fcf191129188b159e4e6d679a293);
        read_one("cb_rk10", 10, 128'h28fddef86da4244accc0a4fe3b316f26);

        // Busy rejection, back-to-back acceptance, read-during-write.
        key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        expand_ref(key_b);
        b_rk3 = ref_rk[3];
        expand_ref(key_a);
        a_rk3  = ref_rk[3];
        a_rk10 = ref_rk[10];
        accept("busyA", key_a);
        repeat (2) @(negedge clk);
        bus.key_in    = key_b;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk("busyA_still_busy", 128'(bus.busy), 128'(1));
        repeat (2) @(negedge clk);
        bus.key_valid = 1'b1;
        wait_done("busyA", 5);
        bus.rk_addr = 4'd10;
        chk("busyA_kv_before_e11", 128'(bus.keys_valid), 128'(1));
        @(negedge clk);
        chk("busyB_kv_drop_e11", 128'(bus.keys_valid), 128'(0));
        chk("busyB_busy_e11", 128'(bus.busy), 128'(1));
        chk("busyA_rk10", bus.rk_data, a_rk10);
        bus.key_valid = 1'b0;
        bus.rk_addr   = 4'd3;
        repeat (3) @(negedge clk);
        chk("rdw_old_rk3", bus.rk_data, a_rk3);
        @(negedge clk);
        chk("rdw_new_rk3", bus.rk_data, b_rk3);
        wait_done("busyB", 4);
        expand_ref(key_b);
        read_sweep("busyB", 1'b0);

        // Reset in the middle of an expansion.
        kk = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept("mid", kk);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        read_sweep("midrst", 1'b1);
        expand_ref(kk);
        accept("post", kk);
        wait_done("post", 0);
        read_sweep("post", 1'b0);

        // Random keys with random read addresses.
        for (int n = 0; n < 4; n++) begin
            int a;
            kk = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_ref(kk);
            accept($sformatf("rnd%0d", n), kk);
            wait_done($sformatf("rnd%0d", n), 0);
            for (int j = 0; j < 12; j++) begin
                a = int'($urandom_range(0, 15));
                read_one($sformatf("rnd%0d_rd%0d", n, a), a, (a <= 10) ? ref_rk[a] : 128'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
